// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: scan states and the
// active-high a..g glyph patterns for hex digits.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_DIG0   = 2'd0,
    ST_BLANK0 = 2'd1,
    ST_DIG1   = 2'd2,
    ST_BLANK1 = 2'd3
  } scan_state_e;

  // Active-high patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    pat = SEG_OFF;
    case (nib)
      4'h0: pat = SEG_HEX_0;
      4'h1: pat = SEG_HEX_1;
      4'h2: pat = SEG_HEX_2;
      4'h3: pat = SEG_HEX_3;
      4'h4: pat = SEG_HEX_4;
      4'h5: pat = SEG_HEX_5;
      4'h6: pat = SEG_HEX_6;
      4'h7: pat = SEG_HEX_7;
      4'h8: pat = SEG_HEX_8;
      4'h9: pat = SEG_HEX_9;
      4'hA: pat = SEG_HEX_A;
      4'hB: pat = SEG_HEX_B;
      4'hC: pat = SEG_HEX_C;
      4'hD: pat = SEG_HEX_D;
      4'hE: pat = SEG_HEX_E;
      4'hF: pat = SEG_HEX_F;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to 7-segment decoder, active-high a..g.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_pattern(nibble);

endmodule

// File: rtl/seg7_dual_scan.sv
// Two-digit multiplexed 7-segment driver: digit 0 shows x, digit 1 shows y with
// its decimal point. x/y are snapshotted once per frame on entry to DIG0.
module seg7_dual_scan
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES   = 13500,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_OFF_PIN = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic       DP_OFF_PIN  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [1:0] DIG_OFF_PIN = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

  function automatic logic [6:0] seg_pins(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic dp_pin(input logic d);
    return SEG_ACTIVE_LOW ? ~d : d;
  endfunction

  function automatic logic [1:0] dig_pins(input logic [1:0] d);
    return DIG_ACTIVE_LOW ? ~d : d;
  endfunction

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       x_s_q, x_s_d;
  logic [3:0]       y_s_q, y_s_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [1:0]       dig_q, dig_d;
  logic             frame_tick_q, frame_tick_d;

  logic             phase_done;
  logic             enter_dig0;
  logic [3:0]       dec_nibble;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_ah;
  logic             dp_ah;
  logic [1:0]       dig_ah;

  // Scan sequencer and frame snapshot
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    x_s_d      = x_s_q;
    y_s_d      = y_s_q;
    enter_dig0 = 1'b0;

    if ((state_q == ST_DIG0) || (state_q == ST_DIG1)) begin
      phase_done = (cnt_q == DIGIT_LAST);
    end else begin
      phase_done = (cnt_q == BLANK_LAST);
    end

    if (!en) begin
      state_d = ST_BLANK1;
      cnt_d   = '0;
    end else if (phase_done) begin
      cnt_d = '0;
      case (state_q)
        ST_DIG0:   state_d = ST_BLANK0;
        ST_BLANK0: state_d = ST_DIG1;
        ST_DIG1:   state_d = ST_BLANK1;
        ST_BLANK1: begin
          state_d    = ST_DIG0;
          enter_dig0 = 1'b1;
        end
        default:   state_d = ST_BLANK1;
      endcase
    end

    if (enter_dig0) begin
      x_s_d = x;
      y_s_d = y;
    end
  end

  // Outputs are computed from the next state so they register on the same edge
  assign dec_nibble = (state_d == ST_DIG1) ? y_s_d : x_s_d;

  hex_to_seg7 u_dec (
    .nibble (dec_nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_ah = SEG_OFF;
    dp_ah  = 1'b0;
    dig_ah = 2'b00;
    case (state_d)
      ST_DIG0: begin
        seg_ah = dec_seg;
        dig_ah = 2'b01;
      end
      ST_DIG1: begin
        seg_ah = dec_seg;
        dp_ah  = 1'b1;
        dig_ah = 2'b10;
      end
      default: ;
    endcase

    seg_d        = seg_pins(seg_ah);
    dp_d         = dp_pin(dp_ah);
    dig_d        = dig_pins(dig_ah);
    frame_tick_d = enter_dig0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK1;
      cnt_q        <= '0;
      x_s_q        <= 4'h0;
      y_s_q        <= 4'h0;
      seg_q        <= SEG_OFF_PIN;
      dp_q         <= DP_OFF_PIN;
      dig_q        <= DIG_OFF_PIN;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_s_q        <= x_s_d;
      y_s_q        <= y_s_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig        = dig_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_dual_scan.sv
// Bench for seg7_dual_scan with short digit/blank times; outputs are compared
// every cycle against a frame-position model of the display.
module tb_seg7_dual_scan;

  localparam int DC       = 4;
  localparam int BC       = 2;
  localparam int FRAME    = 2 * (DC + BC);
  localparam int P_DIG0   = 0;
  localparam int P_BLANK0 = DC;
  localparam int P_DIG1   = DC + BC;
  localparam int P_BLANK1 = 2 * DC + BC;
  localparam logic [10:0] ALL_OFF = {7'h7F, 1'b1, 2'b11, 1'b0};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] x;
  logic [3:0] y;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] dig;
  logic       frame_tick;
  wire [10:0] obs = {seg, dp, dig, frame_tick};

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position within the frame, snapshot and tick flag
  int         m_pos;
  logic [3:0] m_xs;
  logic [3:0] m_ys;
  logic       m_tick;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_dual_scan #(
    .DIGIT_CYCLES   (DC),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .x          (x),
    .y          (y),
    .seg        (seg),
    .dp         (dp),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_pos  = P_BLANK1;
    m_tick = 1'b0;
    m_xs   = 4'h0;
    m_ys   = 4'h0;
  endtask

  function automatic logic [10:0] model_out();
    logic [6:0] s = 7'h7F;
    logic       d = 1'b1;
    logic [1:0] g = 2'b11;
    if (m_pos < P_BLANK0) begin
      s = ~hex_tbl[m_xs];
      g = 2'b10;
    end else if (m_pos >= P_DIG1 && m_pos < P_BLANK1) begin
      s = ~hex_tbl[m_ys];
      d = 1'b0;
      g = 2'b01;
    end
    return {s, d, g, m_tick};
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (!en) begin
      m_pos  = P_BLANK1;
      m_tick = 1'b0;
    end else begin
      m_pos  = (m_pos + 1) % FRAME;
      m_tick = (m_pos == P_DIG0);
      if (m_tick) begin
        m_xs = x;
        m_ys = y;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    x     = 4'h3;
    y     = 4'hD;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== ALL_OFF) begin
      n_bad++;
      $display("FAIL reset_hold got=%h exp=%h", obs, ALL_OFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL first_frame cyc=%0d got=%h exp=%h", i, obs, model_out());
      end
      if (i == BC - 1) begin
        n_cmp++;
        if ({frame_tick, dig, seg} !== {1'b1, 2'b10, 7'h30}) begin
          n_bad++;
          $display("FAIL first_tick tick/dig/seg got=%b/%b/%h exp=1/10/30", frame_tick, dig, seg);
        end
      end
      if (i == BC - 1 + P_DIG1) begin
        n_cmp++;
        if ({dig, seg, dp} !== {2'b01, 7'h21, 1'b0}) begin
          n_bad++;
          $display("FAIL first_dig1 dig/seg/dp got=%b/%h/%b exp=01/21/0", dig, seg, dp);
        end
      end
    end
  endtask

  task automatic test_tearing();
    int guard;
    guard = 0;
    while (m_pos != P_DIG1 + 1 && guard < 2 * FRAME) begin
      step();
      guard++;
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL tear_pre got=%h exp=%h", obs, model_out());
      end
    end
    x = 4'h7;
    guard = 0;
    do begin
      step();
      guard++;
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL tear_wait got=%h exp=%h", obs, model_out());
      end
    end while (!frame_tick && guard < FRAME + 1);
    n_cmp++;
    if (!frame_tick || seg !== 7'h78) begin
      n_bad++;
      $display("FAIL tear_new_value tick/seg got=%b/%h exp=1/78", frame_tick, seg);
    end
  endtask

  task automatic test_frame_timing();
    int last_tick = -1;
    int off_run = 0;
    logic seen = 1'b0;
    logic [1:0] prev_dig = 2'b11;
    int ticks = 0;
    for (int c = 0; c < 10 * FRAME + 2; c++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      step();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL timing_model cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (dig === 2'b00) begin
        n_bad++;
        $display("FAIL timing_two_digits cyc=%0d got dig=%b", c, dig);
      end
      if (frame_tick) begin
        if (last_tick >= 0) begin
          n_cmp++;
          if (c - last_tick != FRAME) begin
            n_bad++;
            $display("FAIL tick_spacing got=%0d exp=%0d", c - last_tick, FRAME);
          end
        end
        last_tick = c;
        ticks++;
      end
      if (dig !== 2'b11) begin
        if (seen && dig !== prev_dig) begin
          n_cmp++;
          if (off_run < BC) begin
            n_bad++;
            $display("FAIL blank_gap got=%0d exp>=%0d", off_run, BC);
          end
        end
        seen = 1'b1;
        off_run = 0;
      end else begin
        off_run++;
      end
      prev_dig = dig;
    end
    n_cmp++;
    if (ticks < 10) begin
      n_bad++;
      $display("FAIL tick_count got=%0d exp>=10", ticks);
    end
  endtask

  task automatic test_enable();
    int guard;
    int edges;
    guard = 0;
    while (m_pos != P_DIG0 + 1 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    en = 1'b0;
    step();
    n_cmp++;
    if (obs !== ALL_OFF) begin
      n_bad++;
      $display("FAIL en_off got=%h exp=%h", obs, ALL_OFF);
    end
    for (int i = 0; i < 4; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      step();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL en_hold got=%h exp=%h", obs, model_out());
      end
    end
    en = 1'b1;
    x  = 4'($urandom_range(0, 15));
    y  = 4'($urandom_range(0, 15));
    edges = 0;
    do begin
      step();
      edges++;
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL en_resume got=%h exp=%h", obs, model_out());
      end
    end while (!frame_tick && edges < 8);
    n_cmp++;
    if (edges != BC || seg !== ~hex_tbl[x]) begin
      n_bad++;
      $display("FAIL en_tick edges/seg got=%0d/%h exp=%0d/%h", edges, seg, BC, ~hex_tbl[x]);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    x = 4'h3;
    y = 4'hD;
    guard = 0;
    while (m_pos != P_DIG1 + 1 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (obs !== ALL_OFF) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h", obs, ALL_OFF);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL restart cyc=%0d got=%h exp=%h", i, obs, model_out());
      end
      if (i == BC - 1) begin
        n_cmp++;
        if ({frame_tick, dig, seg} !== {1'b1, 2'b10, 7'h30}) begin
          n_bad++;
          $display("FAIL restart_tick tick/dig/seg got=%b/%b/%h exp=1/10/30", frame_tick, dig, seg);
        end
      end
    end
  endtask

  task automatic test_decode_sweep();
    int guard;
    for (int v = 0; v < 16; v++) begin
      guard = 0;
      while (m_pos != FRAME - 1 && guard < 2 * FRAME) begin
        step();
        guard++;
      end
      x = 4'(v);
      y = 4'(15 - v);
      for (int c = 0; c < FRAME; c++) begin
        step();
        n_cmp++;
        if (obs !== model_out()) begin
          n_bad++;
          $display("FAIL sweep v=%0d cyc=%0d got=%h exp=%h", v, c, obs, model_out());
        end
        if (dp !== (dig === 2'b01 ? 1'b0 : 1'b1)) begin
          n_bad++;
          $display("FAIL sweep_dp v=%0d got dp=%b dig=%b", v, dp, dig);
        end
        if (c == 0) begin
          n_cmp++;
          if (seg !== ~hex_tbl[v]) begin
            n_bad++;
            $display("FAIL sweep_seg0 v=%0d got=%h exp=%h", v, seg, ~hex_tbl[v]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      x  = 4'($urandom_range(0, 15));
      y  = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 15) != 0);
      step();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, model_out());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    x     = 4'h0;
    y     = 4'h0;
    model_reset();
    test_reset();
    test_tearing();
    test_frame_timing();
    test_enable();
    test_async_reset();
    test_decode_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
